inst_prefetch: RTL

INST_PREFETCH -- requirements
Module: inst_prefetch

---
 rtl/inst_prefetch_pkg.sv | 33 +++
 rtl/inst_fifo.sv | 94 +++++++++
 rtl/inst_prefetch.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_pkg.sv
// ============================================================================
// Module      : inst_prefetch_pkg
// Description : Shared types and constants for the instruction prefetcher:
//               fetch FSM state encoding, NOP encoding, instruction/address
//               types and the queue entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package inst_prefetch_pkg;

    typedef logic [15:0] instr_t;
    typedef logic [15:0] addr_t;

    // IDLE: nothing outstanding, WAIT: live request outstanding,
    // DISCARD: request outstanding whose data must be dropped.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam instr_t NOP_INSTR = 16'h1000;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/inst_fifo.sv
// ============================================================================
// Module      : inst_fifo
// Description : Instruction queue of {pc, instr} entries. Push and pop may
//               happen in the same cycle even when full; flush empties the
//               queue and overrides any same-cycle push or pop.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module inst_fifo
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output fetch_entry_t             head_entry
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_W = DEPTH[CNT_W-1:0];

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               w_full, w_empty, w_do_push, w_do_pop, w_wr_en;

    // Pointer and occupancy update; flush has priority over push and pop.
    always_comb begin
        w_empty   = (count_q == '0);
        w_full    = (count_q == DEPTH_W);
        w_do_pop  = pop && !w_empty;
        w_do_push = push && (!w_full || w_do_pop);
        w_wr_en   = w_do_push && !flush;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the count, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign full       = w_full;
    assign empty      = w_empty;
    assign count      = count_q;
    assign head_entry = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/inst_prefetch.sv
// ============================================================================
// Module      : inst_prefetch
// Description : Instruction prefetcher. Issues word-addressed fetches with at
//               most one outstanding request, queues returned instructions
//               with their PC and presents them to decode. Redirects flush
//               the queue and retarget the fetch PC; in-flight data is dropped.
//               Optional macro INST_PREFETCH_BYPASS_EN forwards ack data
//               straight to the outputs when the queue is empty and decode is
//               ready.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        out_valid,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    input  logic        out_ready
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_W = DEPTH[CNT_W:0];

    fetch_state_t       state_q, state_d;
    addr_t              pc_q,    pc_d;
    addr_t              addr_q,  addr_d;

    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    fetch_entry_t       w_fifo_head;
    fetch_entry_t       w_fetched;
    logic [CNT_W:0]     w_occupancy;
    logic               w_credit_ok;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_bypass;

    assign w_fetched = '{pc: addr_q, instr: mem_rdata};

    // Next-state logic: request issue, ack handling and redirect retargeting.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        addr_d      = addr_q;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_bypass    = 1'b0;
        // A live outstanding request already owns one queue slot.
        w_occupancy = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, (state_q == WAIT)};
        w_credit_ok = (w_occupancy < DEPTH_W);
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (!halt && w_credit_ok) begin
                    w_issue = 1'b1;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = mem_ack ? IDLE : DISCARD;
                end else if (mem_ack) begin
`ifdef INST_PREFETCH_BYPASS_EN
                    w_bypass = w_fifo_empty && out_ready;
`endif
                    w_push  = !w_bypass;
                    state_d = IDLE;
                    if (!halt && w_credit_ok) begin
                        w_issue = 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (w_issue) begin
            state_d = WAIT;
            addr_d  = pc_q;
            pc_d    = pc_q + 16'd1;
        end
    end

    // FSM, fetch PC and request address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
        end
    end

    // Decode-side outputs: queue head, NOP when empty, or forwarded ack data.
    always_comb begin
        out_valid = !w_fifo_empty;
        out_instr = w_fifo_empty ? NOP_INSTR : w_fifo_head.instr;
        out_pc    = w_fifo_empty ? 16'h0000  : w_fifo_head.pc;
        if (w_bypass) begin
            out_valid = 1'b1;
            out_instr = mem_rdata;
            out_pc    = addr_q;
        end
        w_pop = !w_fifo_empty && out_ready;
    end

    assign mem_req  = (state_q != IDLE);
    assign mem_addr = addr_q;

    inst_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_entry (w_fetched),
        .pop        (w_pop),
        .flush      (redirect),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty),
        .count      (w_fifo_count),
        .head_entry (w_fifo_head)
    );

    // Full is implied by the credit check; kept visible for debug.
    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule

`default_nettype wire
